// File: rtl/spi_reg_burst.sv
// SPI mode-0 slave bridging a host to a peripheral register bus, with
// configurable address/data widths, burst transfers and a read strobe.
module spi_reg_burst #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int AUTO_INC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] reg_data_o,
    output logic              reg_data_o_dv,
    output logic              reg_rd_strobe,
    output logic              busy
);

    localparam int HDR_W = 8 * ((ADDR_W + 8) / 8);
    localparam int MAX_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_WR   = 2'd2,
        S_RD   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic              sck_prev_q;
    logic              cs_prev_q;
    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_sh_q;
    logic [DATA_W-1:0] shift_q;
    logic              wr_pend_q;
    logic              rd_load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_o_q;
    logic              dv_q;
    logic              strobe_q;
    logic              miso_q;
    logic              busy_q;

    logic              sck_s;
    logic              cs_s;
    logic              mosi_s;
    logic              sck_rise_s;
    logic              sck_fall_s;
    logic              cs_fall_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [DATA_W-1:0] shift_in_s;

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise_s  = sck_s & ~sck_prev_q;
    assign sck_fall_s  = ~sck_s & sck_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;
    assign addr_next_s = (addr_sh_q << 1) | ADDR_W'(mosi_s);
    assign shift_in_s  = (shift_q << 1) | DATA_W'(mosi_s);

    // Input synchronisers; chip select idles high so reset cannot fake a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    // Frame FSM with bus-side write commit and read prefetch pipelines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            rw_q       <= 1'b0;
            addr_sh_q  <= '0;
            shift_q    <= '0;
            wr_pend_q  <= 1'b0;
            rd_load_q  <= 1'b0;
            addr_q     <= '0;
            data_o_q   <= '0;
            dv_q       <= 1'b0;
            strobe_q   <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            dv_q       <= 1'b0;
            strobe_q   <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_load_q  <= 1'b0;

            // A completed word is committed even if the frame has just closed
            if (wr_pend_q) begin
                data_o_q <= shift_q;
                dv_q     <= 1'b1;
            end
            if (dv_q && (AUTO_INC != 0)) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    bit_cnt_q <= '0;
                    miso_q    <= 1'b0;
                    if (cs_fall_s) begin
                        state_q <= S_HDR;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_HDR, S_WR, S_RD: begin
                    if (cs_s) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        miso_q    <= 1'b0;
                    end else if (state_q == S_HDR) begin
                        if (sck_rise_s) begin
                            addr_sh_q <= addr_next_s;
                            if (bit_cnt_q == '0) begin
                                rw_q <= mosi_s;
                            end
                            if (bit_cnt_q == HDR_LAST) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_next_s;
                                if (rw_q) begin
                                    state_q <= S_WR;
                                end else begin
                                    state_q   <= S_RD;
                                    rd_load_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end else if (state_q == S_WR) begin
                        if (sck_rise_s) begin
                            shift_q <= shift_in_s;
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                wr_pend_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        if (rd_load_q) begin
                            shift_q  <= reg_data_i;
                            miso_q   <= reg_data_i[DATA_W-1];
                            strobe_q <= 1'b1;
                        end else if (sck_rise_s) begin
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                rd_load_q <= 1'b1;
                                if (AUTO_INC != 0) begin
                                    addr_q <= addr_q + ADDR_W'(1);
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end else if (sck_fall_s && (bit_cnt_q != '0)) begin
                            // No shift on the fall after a word boundary: the fresh MSB must hold
                            shift_q <= shift_q << 1;
                            miso_q  <= shift_q[DATA_W-2];
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign spi_miso      = miso_q;
    assign reg_addr      = addr_q;
    assign reg_data_o    = data_o_q;
    assign reg_data_o_dv = dv_q;
    assign reg_rd_strobe = strobe_q;
    assign busy          = busy_q;

endmodule
